// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory port arbiter.
package mem_arb_pkg;
  localparam int AW             = 32;
  localparam int DW             = 32;
  localparam int MEM_RD_LATENCY = 1;

  typedef enum logic [1:0] {IDLE, GNT_CPU, GNT_LDR} arb_state_t;
  typedef enum logic {REQ_CPU, REQ_LDR} req_id_t;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } mem_cmd_t;
endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection; on a tie the requester that did not win last time goes first.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic    cpu_req,
  input  logic    ldr_req,
  input  req_id_t last_win,
  output logic    any_req,
  output req_id_t winner
);
  always_comb begin
    any_req = cpu_req | ldr_req;
    winner  = REQ_CPU;
    if (cpu_req && ldr_req) winner = (last_win == REQ_CPU) ? REQ_LDR : REQ_CPU;
    else if (ldr_req)       winner = REQ_LDR;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates CPU and loader onto one single-port memory, one access per cycle.
// Define MEM_ARB_FAIR_EN for round-robin ties; otherwise the CPU always wins ties.
module mem_port_arbiter
  import mem_arb_pkg::*;
(
  input  logic          Clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          ldr_req,
  input  logic          ldr_wr,
  input  logic [AW-1:0] ldr_addr,
  input  logic [DW-1:0] ldr_wdata,
  output logic          ldr_gnt,
  output logic          ldr_rvalid,
  output logic [DW-1:0] ldr_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);
  arb_state_t state, state_nxt;
  req_id_t    last_win, winner;
  logic       any_req, rd_go;
  mem_cmd_t   cmd_q;
  logic [MEM_RD_LATENCY:1] vld_pipe, ldr_pipe;
  logic [DW-1:0] cpu_rdata_q, ldr_rdata_q;

  mem_arb_pick u_pick (
    .cpu_req (cpu_req),
    .ldr_req (ldr_req),
    .last_win(last_win),
    .any_req (any_req),
    .winner  (winner)
  );

`ifdef MEM_ARB_FAIR_EN
  // Reset value "loader won last" hands the first tie to the CPU.
  always_ff @(posedge Clk or posedge reset)
    if (reset)        last_win <= REQ_LDR;
    else if (any_req) last_win <= winner;
`else
  assign last_win = REQ_LDR;
`endif

  always_ff @(posedge Clk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= state_nxt;

  always_comb begin
    state_nxt = IDLE;
    if (any_req) state_nxt = (winner == REQ_LDR) ? GNT_LDR : GNT_CPU;
  end

  always_comb begin
    cpu_gnt = (state == GNT_CPU);
    ldr_gnt = (state == GNT_LDR);
    mem_wr  = (state != IDLE) && cmd_q.wr;
    rd_go   = (state != IDLE) && !cmd_q.wr;
  end

  // Address/data hold through IDLE; only mem_wr is qualified by state.
  always_ff @(posedge Clk or posedge reset)
    if (reset)        cmd_q <= '0;
    else if (any_req) cmd_q <= (winner == REQ_LDR) ? mem_cmd_t'{ldr_wr, ldr_addr, ldr_wdata}
                                                   : mem_cmd_t'{cpu_wr, cpu_addr, cpu_wdata};

  assign mem_addr  = cmd_q.addr;
  assign mem_wdata = cmd_q.wdata;

  // Read-return tracking; a reset drops any read still in flight.
  always_ff @(posedge Clk or posedge reset)
    if (reset) begin
      vld_pipe <= '0;
      ldr_pipe <= '0;
    end else begin
      vld_pipe[1] <= rd_go;
      ldr_pipe[1] <= (state == GNT_LDR);
      for (int i = 2; i <= MEM_RD_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        ldr_pipe[i] <= ldr_pipe[i-1];
      end
    end

  assign cpu_rvalid = vld_pipe[MEM_RD_LATENCY] & ~ldr_pipe[MEM_RD_LATENCY];
  assign ldr_rvalid = vld_pipe[MEM_RD_LATENCY] &  ldr_pipe[MEM_RD_LATENCY];

  always_ff @(posedge Clk or posedge reset)
    if (reset) begin
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
    end else begin
      if (cpu_rvalid) cpu_rdata_q <= mem_rdata;
      if (ldr_rvalid) ldr_rdata_q <= mem_rdata;
    end

  assign cpu_rdata = cpu_rvalid ? mem_rdata : cpu_rdata_q;
  assign ldr_rdata = ldr_rvalid ? mem_rdata : ldr_rdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Table-driven bench for mem_port_arbiter with a read-return scoreboard and a memory model.
module tb_mem_port_arbiter;
`ifdef MEM_ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic        Clk = 1'b0, reset = 1'b1;
  logic        cpu_req = 0, cpu_wr = 0, ldr_req = 0, ldr_wr = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0, ldr_addr = 0, ldr_wdata = 0;
  logic        cpu_gnt, cpu_rvalid, ldr_gnt, ldr_rvalid, mem_wr;
  logic [31:0] cpu_rdata, ldr_rdata, mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 0;

  always #5 Clk = ~Clk;

  mem_port_arbiter dut (
    .Clk(Clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .ldr_req(ldr_req), .ldr_wr(ldr_wr), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_gnt(ldr_gnt), .ldr_rvalid(ldr_rvalid), .ldr_rdata(ldr_rdata),
    .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEAD_BEEF : (32'hA000_0000 | a);
  endfunction

  // Memory model: synchronous write, registered read one cycle after the address cycle.
  logic [31:0] tb_mem [256];
  bit          tb_wv  [256];
  always @(posedge Clk) begin
    if (mem_wr) begin
      tb_mem[mem_addr[9:2]] <= mem_wdata;
      tb_wv[mem_addr[9:2]]  <= 1'b1;
    end
    mem_rdata <= tb_wv[mem_addr[9:2]] ? tb_mem[mem_addr[9:2]] : init_val(mem_addr);
  end

  // Bench's own reference of memory contents.
  logic [31:0] ref_mem [256];
  bit          ref_wv  [256];
  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_wv[a[9:2]] ? ref_mem[a[9:2]] : init_val(a);
  endfunction

  typedef struct {
    logic        cpu_req, cpu_wr;
    logic [31:0] cpu_addr, cpu_wdata;
    logic        ldr_req, ldr_wr;
    logic [31:0] ldr_addr, ldr_wdata;
    logic        exp_cg, exp_lg;
  } vec_t;

  typedef struct {
    logic        is_ldr;
    logic [31:0] data;
  } rd_exp_t;

  rd_exp_t     sb [$];
  int          n_tests = 0, n_fail = 0;
  logic [31:0] last_c = 0, last_l = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic cr, cw, input logic [31:0] ca, cd,
                              input logic lr, lw, input logic [31:0] la, ld,
                              input logic eg_c, eg_l);
    vec_t v;
    v.cpu_req = cr; v.cpu_wr = cw; v.cpu_addr = ca; v.cpu_wdata = cd;
    v.ldr_req = lr; v.ldr_wr = lw; v.ldr_addr = la; v.ldr_wdata = ld;
    v.exp_cg = eg_c; v.exp_lg = eg_l;
    return v;
  endfunction

  // Drive one vector for one cycle and check the grant it produces one edge later.
  task automatic apply(input vec_t v);
    logic        w;
    logic [31:0] a, d;
    cpu_req = v.cpu_req; cpu_wr = v.cpu_wr; cpu_addr = v.cpu_addr; cpu_wdata = v.cpu_wdata;
    ldr_req = v.ldr_req; ldr_wr = v.ldr_wr; ldr_addr = v.ldr_addr; ldr_wdata = v.ldr_wdata;
    @(posedge Clk); #1;
    check("cpu_gnt", {31'd0, cpu_gnt}, {31'd0, v.exp_cg});
    check("ldr_gnt", {31'd0, ldr_gnt}, {31'd0, v.exp_lg});
    w = v.exp_cg ? v.cpu_wr   : v.exp_lg ? v.ldr_wr   : 1'b0;
    a = v.exp_cg ? v.cpu_addr : v.ldr_addr;
    d = v.exp_cg ? v.cpu_wdata : v.ldr_wdata;
    check("mem_wr", {31'd0, mem_wr}, {31'd0, w});
    if (v.exp_cg || v.exp_lg) begin
      check("mem_addr", mem_addr, a);
      if (w) begin
        check("mem_wdata", mem_wdata, d);
        ref_mem[a[9:2]] = d;
        ref_wv[a[9:2]]  = 1'b1;
      end else begin
        sb.push_back('{is_ldr: v.exp_lg, data: ref_rd(a)});
      end
    end
  endtask

  // Return-path monitor: every rvalid must match the oldest outstanding read; rdata holds otherwise.
  always @(negedge Clk) begin
    if (reset) begin
      last_c = 0;
      last_l = 0;
    end else if (cpu_rvalid || ldr_rvalid) begin
      if (sb.size() == 0) begin
        check("rvalid_unexpected", {30'd0, cpu_rvalid, ldr_rvalid}, 32'd0);
      end else begin
        rd_exp_t e;
        e = sb.pop_front();
        check("rvalid_owner", {30'd0, cpu_rvalid, ldr_rvalid}, e.is_ldr ? 32'd1 : 32'd2);
        if (e.is_ldr) begin check("ldr_rdata", ldr_rdata, e.data); last_l = e.data; end
        else          begin check("cpu_rdata", cpu_rdata, e.data); last_c = e.data; end
      end
    end else begin
      check("cpu_rdata_hold", cpu_rdata, last_c);
      check("ldr_rdata_hold", ldr_rdata, last_l);
    end
  end

  vec_t idle_v;
  vec_t tbl [$];

  initial begin
    idle_v = mk(0,0,0,0, 0,0,0,0, 0,0);
    for (int i = 0; i < 5; i++) tbl.push_back(idle_v);                       // idle bus
    tbl.push_back(mk(1,0,32'h10,0,        0,0,0,0,              1,0));       // single CPU read
    tbl.push_back(idle_v);
    tbl.push_back(mk(0,0,0,0,             1,1,32'h20,32'h1234,  0,1));       // loader write
    tbl.push_back(mk(1,0,32'h20,0,        0,0,0,0,              1,0));       // CPU reads it back
    tbl.push_back(mk(1,0,32'h0,0,         0,0,0,0,              1,0));       // back-to-back reads
    tbl.push_back(mk(1,0,32'h4,0,         0,0,0,0,              1,0));
    tbl.push_back(mk(1,0,32'h8,0,         0,0,0,0,              1,0));
    tbl.push_back(mk(0,0,0,0,             1,0,32'h10,0,         0,1));       // loader read, loader won last
    for (int k = 0; k < 4; k++)                                              // both held for 4 edges
      tbl.push_back(mk(1,0,32'h4,0, 1,0,32'h8,0,
                       FAIR ? (k % 2 == 0) : 1'b1, FAIR ? (k % 2 == 1) : 1'b0));
    tbl.push_back(idle_v);
    tbl.push_back(idle_v);

    repeat (2) @(posedge Clk);
    #1;
    check("rst_cpu_gnt",    {31'd0, cpu_gnt},    32'd0);
    check("rst_ldr_gnt",    {31'd0, ldr_gnt},    32'd0);
    check("rst_mem_wr",     {31'd0, mem_wr},     32'd0);
    check("rst_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd0);
    check("rst_mem_addr",   mem_addr,            32'd0);
    check("rst_mem_wdata",  mem_wdata,           32'd0);
    check("rst_cpu_rdata",  cpu_rdata,           32'd0);
    reset = 1'b0;

    foreach (tbl[i]) apply(tbl[i]);

    // Reset lands in the grant cycle of a read to 0x30; that read must never return.
    apply(mk(1,0,32'h30,0, 0,0,0,0, 1,0));
    reset = 1'b1;
    sb.delete();
    cpu_req = 1'b0;
    #1;
    check("arst_cpu_gnt",    {31'd0, cpu_gnt},    32'd0);
    check("arst_mem_wr",     {31'd0, mem_wr},     32'd0);
    check("arst_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd0);
    check("arst_ldr_rvalid", {31'd0, ldr_rvalid}, 32'd0);
    check("arst_mem_addr",   mem_addr,            32'd0);
    check("arst_cpu_rdata",  cpu_rdata,           32'd0);
    check("arst_ldr_rdata",  ldr_rdata,           32'd0);
    @(posedge Clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) apply(idle_v);

    // First tie after reset goes to the CPU in either mode.
    apply(mk(1,0,32'h10,0, 1,0,32'h0,0, 1,0));
    apply(mk(1,0,32'h10,0, 1,0,32'h0,0, !FAIR, FAIR));
    for (int i = 0; i < 3; i++) apply(idle_v);

    check("sb_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Port Clk, input, 1: the single clock; all state changes on its rising edge.
REQ-002 Port reset, input, 1: asynchronous, active-high reset.
REQ-003 Ports cpu_req / cpu_wr, input, 1 each: CPU access request; 1 = write, 0 = read.
REQ-004 Ports cpu_addr / cpu_wdata, input, 32 each: CPU byte address and write data.
REQ-005 Port cpu_gnt, output, 1: CPU access is on the memory port this cycle.
REQ-006 Ports cpu_rvalid (output, 1) and cpu_rdata (output, 32): CPU read data return.
REQ-007 Ports ldr_req, ldr_wr, ldr_addr, ldr_wdata, ldr_gnt, ldr_rvalid, ldr_rdata: loader/debug requester; same widths and meanings as the CPU ports.
REQ-008 Ports mem_addr (output, 32), mem_wr (output, 1), mem_wdata (output, 32): drive the single-port Memoria.
REQ-009 Port mem_rdata, input, 32: Memoria read data, valid one cycle after the address cycle.

Function
REQ-010 The FSM SHALL have three states: IDLE, GNT_CPU and GNT_LDR.
REQ-011 Arbitration SHALL occur on each rising edge from any state, using the sampled cpu_req and ldr_req: winner goes to GNT_<winner>; no request goes to IDLE.
REQ-012 The winner's wr, addr and wdata SHALL be registered at the decision edge and driven on mem_wr, mem_addr and mem_wdata for the whole grant cycle.
REQ-013 gnt_x SHALL be 1 for exactly the one cycle spent in GNT_x; gnt doubles as the write acknowledge.
REQ-014 Request-to-grant latency SHALL be 1 cycle: req sampled at edge N, gnt high in cycle N+1.
REQ-015 For reads, rvalid_x SHALL pulse in the cycle after the grant cycle, with rdata_x equal to mem_rdata; writes produce no rvalid.
REQ-016 rdata_x SHALL hold its last returned value while rvalid_x is low.
REQ-017 Back-to-back grants SHALL be allowed, giving one access per cycle; a read return may overlap the next grant.
REQ-018 A requester SHALL hold req and its fields stable until it sees gnt. A req still high in the grant cycle SHALL count as a new request.
REQ-019 mem_wr SHALL be 0 in IDLE; mem_addr and mem_wdata SHALL hold their last values in IDLE.
REQ-020 Both requesting at the same edge: the winner is set by REQ-025 or REQ-026.

Reset
REQ-021 On reset assertion, all of the following SHALL clear asynchronously: state to IDLE; gnt, rvalid, mem_wr to 0; mem_addr, mem_wdata, rdata to 0.
REQ-022 A read granted in the cycle before reset SHALL NOT produce rvalid after reset releases.
REQ-023 The fairness pointer (REQ-025) SHALL reset to "CPU has priority".
REQ-024 The first arbitration SHALL happen at the first rising edge after reset deasserts.

Configuration
REQ-025 With MEM_ARB_FAIR_EN defined, arbitration SHALL be round-robin on a 1-bit last-winner pointer. On a tie, the requester that did not win last time wins; the pointer updates on every grant.
REQ-026 Without MEM_ARB_FAIR_EN, the CPU SHALL always win ties, and the loader SHALL be granted only at edges where cpu_req = 0.

Structure
REQ-027 Package mem_arb_pkg SHALL hold:
- the state enum typedef (IDLE, GNT_CPU, GNT_LDR);
- the requester-id enum (REQ_CPU, REQ_LDR);
- localparam MEM_RD_LATENCY = 1.
REQ-028 One sub-module, mem_arb_pick, SHALL hold the combinational winner selection (two reqs plus pointer to winner id). The FSM, registers and return path SHALL stay in mem_port_arbiter.

Verification
REQ-029 Single CPU read: cpu_req=1, cpu_wr=0, cpu_addr=0x10, memory[0x10]=0xDEADBEEF.
- Required: cpu_gnt one cycle later; cpu_rvalid the next cycle with cpu_rdata=0xDEADBEEF.
REQ-030 Loader write then CPU read: ldr writes 0x0000_1234 to 0x20, then cpu reads 0x20.
- Required: ldr_gnt with mem_wr=1, no ldr_rvalid; cpu_rdata=0x0000_1234.
REQ-031 Simultaneous requests held for 4 edges, both reqs held high.
- Without MEM_ARB_FAIR_EN: grants CPU,CPU,CPU,CPU.
- With MEM_ARB_FAIR_EN: grants CPU,LDR,CPU,LDR.
REQ-032 Back-to-back CPU reads at 0x0, 0x4, 0x8: grants in 3 consecutive cycles; rvalid in the 3 following consecutive cycles, data in order.
REQ-033 Reset during a read: reset asserted in the grant cycle of a read to 0x30.
- Required: gnt, rvalid and mem_wr go to 0 immediately; no rvalid after release.
REQ-034 Idle bus: no requests for 5 cycles. Required: mem_wr=0 and no gnt or rvalid throughout.
